// File: rtl/axil_register_arbiter.sv
// axil_register_arbiter
//
// Shares one AXI4-Lite register slave (m00) between two requesters (s0 = host
// control path, s1 = on-kernel sequencer). Whole transactions are serialised:
// one read or write is outstanding downstream at a time. Requesters are chosen
// round-robin, and within a requester a pending write beats a pending read.
// All handshakes are passed through combinationally in the granted phase.
// Only the state, the owner, last_grant and the AW/W done flags are registered.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s0_axi_*, s1_axi_*  upstream AXI4-Lite slave ports (AW, W, B, AR, R)
//   m00_axi_*           downstream AXI4-Lite master port to the register slave
//   grant               one-hot owner of the current transaction, 00 when idle
//   busy                high whenever a transaction is in progress
module axil_register_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  output logic [1:0]              s0_axi_bresp,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  // requester 1
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  output logic [1:0]              s1_axi_bresp,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  // downstream register slave
  output logic                    m00_axi_awvalid,
  input  logic                    m00_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic                    m00_axi_wvalid,
  input  logic                    m00_axi_wready,
  output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
  input  logic                    m00_axi_bvalid,
  output logic                    m00_axi_bready,
  input  logic [1:0]              m00_axi_bresp,
  output logic                    m00_axi_arvalid,
  input  logic                    m00_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
  input  logic                    m00_axi_rvalid,
  output logic                    m00_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]              m00_axi_rresp,
  // status
  output logic [1:0]              grant,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  // Upstream signals gathered into two-entry arrays so the owner index selects them.
  logic                    awvalid_s [2];
  logic [ADDR_WIDTH-1:0]   awaddr_s  [2];
  logic                    wvalid_s  [2];
  logic [DATA_WIDTH-1:0]   wdata_s   [2];
  logic [DATA_WIDTH/8-1:0] wstrb_s   [2];
  logic                    bready_s  [2];
  logic                    arvalid_s [2];
  logic [ADDR_WIDTH-1:0]   araddr_s  [2];
  logic                    rready_s  [2];

  logic                    awready_s [2];
  logic                    wready_s  [2];
  logic                    bvalid_s  [2];
  logic [1:0]              bresp_s   [2];
  logic                    arready_s [2];
  logic                    rvalid_s  [2];
  logic [DATA_WIDTH-1:0]   rdata_s   [2];
  logic [1:0]              rresp_s   [2];

  assign awvalid_s = '{s0_axi_awvalid, s1_axi_awvalid};
  assign awaddr_s  = '{s0_axi_awaddr,  s1_axi_awaddr};
  assign wvalid_s  = '{s0_axi_wvalid,  s1_axi_wvalid};
  assign wdata_s   = '{s0_axi_wdata,   s1_axi_wdata};
  assign wstrb_s   = '{s0_axi_wstrb,   s1_axi_wstrb};
  assign bready_s  = '{s0_axi_bready,  s1_axi_bready};
  assign arvalid_s = '{s0_axi_arvalid, s1_axi_arvalid};
  assign araddr_s  = '{s0_axi_araddr,  s1_axi_araddr};
  assign rready_s  = '{s0_axi_rready,  s1_axi_rready};

  assign s0_axi_awready = awready_s[0];
  assign s0_axi_wready  = wready_s[0];
  assign s0_axi_bvalid  = bvalid_s[0];
  assign s0_axi_bresp   = bresp_s[0];
  assign s0_axi_arready = arready_s[0];
  assign s0_axi_rvalid  = rvalid_s[0];
  assign s0_axi_rdata   = rdata_s[0];
  assign s0_axi_rresp   = rresp_s[0];
  assign s1_axi_awready = awready_s[1];
  assign s1_axi_wready  = wready_s[1];
  assign s1_axi_bvalid  = bvalid_s[1];
  assign s1_axi_bresp   = bresp_s[1];
  assign s1_axi_arready = arready_s[1];
  assign s1_axi_rvalid  = rvalid_s[1];
  assign s1_axi_rdata   = rdata_s[1];
  assign s1_axi_rresp   = rresp_s[1];

  state_t state_q, state_d;
  logic   owner_q, owner_d;       // index of the granted requester
  logic   last_q,  last_d;        // index of the last requester to complete
  logic   aw_done_q, aw_done_d;
  logic   w_done_q,  w_done_d;

  logic   req0, req1, pick;
  logic   aw_fin, w_fin;

  assign req0 = awvalid_s[0] | arvalid_s[0];
  assign req1 = awvalid_s[1] | arvalid_s[1];
  // On a tie the requester that did not complete last wins; otherwise whoever asks.
  assign pick = (req0 & req1) ? ~last_q : req1;

  assign busy  = (state_q != IDLE);
  assign grant = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;

    m00_axi_awvalid = 1'b0;
    m00_axi_awaddr  = '0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_wdata   = '0;
    m00_axi_wstrb   = '0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_araddr  = '0;
    m00_axi_rready  = 1'b0;

    for (int i = 0; i < 2; i++) begin
      awready_s[i] = 1'b0;
      wready_s[i]  = 1'b0;
      bvalid_s[i]  = 1'b0;
      bresp_s[i]   = '0;
      arready_s[i] = 1'b0;
      rvalid_s[i]  = 1'b0;
      rdata_s[i]   = '0;
      rresp_s[i]   = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = pick;
          state_d = awvalid_s[pick] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        m00_axi_awvalid     = awvalid_s[owner_q] & ~aw_done_q;
        m00_axi_awaddr      = awaddr_s[owner_q];
        m00_axi_wvalid      = wvalid_s[owner_q] & ~w_done_q;
        m00_axi_wdata       = wdata_s[owner_q];
        m00_axi_wstrb       = wstrb_s[owner_q];
        awready_s[owner_q]  = m00_axi_awready & ~aw_done_q;
        wready_s[owner_q]   = m00_axi_wready & ~w_done_q;
        // AW and W may finish in either order; both finishing this cycle counts.
        aw_fin    = aw_done_q | (m00_axi_awvalid & m00_axi_awready);
        w_fin     = w_done_q  | (m00_axi_wvalid  & m00_axi_wready);
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin & w_fin) state_d = WRESP;
      end
      WRESP: begin
        bvalid_s[owner_q] = m00_axi_bvalid;
        bresp_s[owner_q]  = m00_axi_bresp;
        m00_axi_bready    = bready_s[owner_q];
        if (m00_axi_bvalid & bready_s[owner_q]) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          last_d    = owner_q;
        end
      end
      RADDR: begin
        m00_axi_arvalid    = arvalid_s[owner_q];
        m00_axi_araddr     = araddr_s[owner_q];
        arready_s[owner_q] = m00_axi_arready;
        if (m00_axi_arvalid & m00_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        rvalid_s[owner_q] = m00_axi_rvalid;
        rdata_s[owner_q]  = m00_axi_rdata;
        rresp_s[owner_q]  = m00_axi_rresp;
        m00_axi_rready    = rready_s[owner_q];
        if (m00_axi_rvalid & rready_s[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
